// File: rtl/bloom_ctrl.sv
// bloom_ctrl: sequencing controller between the ibex EX-stage custom-instruction
// interface and the Bloom filter datapath. It issues insert/check strobes,
// waits out the hash latency, runs the clear sweep, and returns a result.
module bloom_ctrl #(
  parameter int unsigned HASH_LAT  = 2,
  parameter int unsigned CLR_WORDS = 16,
  parameter logic [4:0]  OP_INSERT = 5'b00001,
  parameter logic [4:0]  OP_RESET  = 5'b00011,
  parameter logic [4:0]  OP_CHECK  = 5'b00100,
  localparam int unsigned AW = $clog2(CLR_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          custom_en,
  input  logic [4:0]    custom_op_ex,
  input  logic [31:0]   custom_in_RS1,
  output logic          custom_ready,
  output logic          custom_valid,
  output logic [31:0]   custom_result,
  output logic          custom_err,
  output logic [31:0]   bloom_data,
  output logic          bloom_insert,
  output logic          bloom_check,
  output logic          bloom_reset,
  output logic [AW-1:0] bloom_clr_addr,
  input  logic          bloom_match,
  output logic [15:0]   insert_count
);

  // Wait counter needs at least one bit even when HASH_LAT is 1.
  localparam int unsigned WW = (HASH_LAT > 1) ? $clog2(HASH_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INS,
    CHK,
    WAIT,
    CLR,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   data_q;
  logic [31:0]   result_q;
  logic          err_q;
  logic [WW-1:0] wait_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   insert_count_q;

  logic accept;
  assign accept = custom_en && (state_q == IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; all outputs are functions of the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (custom_en) begin
          if (custom_op_ex == OP_INSERT)     state_d = INS;
          else if (custom_op_ex == OP_CHECK) state_d = CHK;
          else if (custom_op_ex == OP_RESET) state_d = CLR;
          else                               state_d = RESP;
        end
      end
      INS:  state_d = RESP;
      CHK:  state_d = WAIT;
      WAIT: if (wait_q == '0) state_d = RESP;
      CLR:  if (addr_q == AW'(CLR_WORDS - 1)) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: element latch, result capture, wait/sweep counters, insert count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q         <= '0;
      result_q       <= '0;
      err_q          <= 1'b0;
      wait_q         <= '0;
      addr_q         <= '0;
      insert_count_q <= '0;
    end else begin
      if (accept) begin
        data_q <= custom_in_RS1;
        if (custom_op_ex == OP_INSERT || custom_op_ex == OP_CHECK ||
            custom_op_ex == OP_RESET) begin
          result_q <= '0;
          err_q    <= 1'b0;
        end else begin
          result_q <= '1;
          err_q    <= 1'b1;
        end
        if (custom_op_ex == OP_RESET) insert_count_q <= '0;
      end
      case (state_q)
        INS: if (insert_count_q != '1) insert_count_q <= insert_count_q + 16'd1;
        CHK: wait_q <= WW'(HASH_LAT - 1);
        WAIT: begin
          if (wait_q == '0) result_q <= {31'b0, bloom_match};
          else              wait_q   <= wait_q - 1'b1;
        end
        // Power-of-two depth: the address wraps to 0 after the last word.
        CLR: addr_q <= addr_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign custom_ready   = (state_q == IDLE);
  assign custom_valid   = (state_q == RESP);
  assign custom_result  = result_q;
  assign custom_err     = err_q;
  assign bloom_data     = data_q;
  assign bloom_insert   = (state_q == INS);
  assign bloom_check    = (state_q == CHK);
  assign bloom_reset    = (state_q == CLR);
  assign bloom_clr_addr = addr_q;
  assign insert_count   = insert_count_q;

endmodule

// File: tb/tb_bloom_ctrl.sv
// Self-checking bench for bloom_ctrl: vector table, hand-written corner
// sequences, and a randomized phase against a transaction-level model.
module tb_bloom_ctrl;

  localparam int unsigned H  = 2;
  localparam int unsigned C  = 16;
  localparam int unsigned AW = 4;
  localparam logic [4:0] OP_INSERT = 5'b00001;
  localparam logic [4:0] OP_RESET  = 5'b00011;
  localparam logic [4:0] OP_CHECK  = 5'b00100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          custom_en = 1'b0;
  logic [4:0]    custom_op_ex = '0;
  logic [31:0]   custom_in_RS1 = '0;
  logic          custom_ready, custom_valid, custom_err;
  logic [31:0]   custom_result, bloom_data;
  logic          bloom_insert, bloom_check, bloom_reset;
  logic [AW-1:0] bloom_clr_addr;
  logic          bloom_match = 1'b0;
  logic [15:0]   insert_count;

  bloom_ctrl #(
    .HASH_LAT (H),
    .CLR_WORDS(C),
    .OP_INSERT(OP_INSERT),
    .OP_RESET (OP_RESET),
    .OP_CHECK (OP_CHECK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .custom_en     (custom_en),
    .custom_op_ex  (custom_op_ex),
    .custom_in_RS1 (custom_in_RS1),
    .custom_ready  (custom_ready),
    .custom_valid  (custom_valid),
    .custom_result (custom_result),
    .custom_err    (custom_err),
    .bloom_data    (bloom_data),
    .bloom_insert  (bloom_insert),
    .bloom_check   (bloom_check),
    .bloom_reset   (bloom_reset),
    .bloom_clr_addr(bloom_clr_addr),
    .bloom_match   (bloom_match),
    .insert_count  (insert_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {custom_ready, custom_valid, custom_result, custom_err, bloom_data,
            bloom_insert, bloom_check, bloom_reset, bloom_clr_addr, insert_count};
  endfunction

  localparam logic [89:0] RESET_OUTS = {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 4'h0, 16'h0};

  // Issue one request from IDLE and wait (bounded) for its completion pulse.
  task automatic do_op(input logic [4:0] op, input logic [31:0] d, output int lat);
    custom_en = 1'b1; custom_op_ex = op; custom_in_RS1 = d;
    @(negedge clk);
    custom_en = 1'b0;
    lat = 1;
    while (!custom_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] d;
    logic        mval;
    int          lat;
    logic [31:0] res;
    logic        err;
    int          n_ins;
    int          n_chk;
    int          n_rst;
  } vec_t;

  vec_t tbl[8];

  // Random-phase model state
  int          m_kind;   // 0 none, 1 insert, 2 check, 3 reset, 4 illegal
  int          m_a;      // accept cycle
  int          m_end;    // completion cycle
  logic [31:0] m_rs, m_data;
  logic [15:0] m_cnt;
  logic        mh[int];

  initial begin
    int lat, k, ni, nc, nr;
    logic [15:0] mc;
    logic seen;

    tbl[0] = '{OP_INSERT, 32'hDEADBEEF, 1'b0, 2,     32'h0,         1'b0, 1, 0, 0};
    tbl[1] = '{OP_CHECK,  32'hCAFEF00D, 1'b1, 2 + H, 32'h1,         1'b0, 0, 1, 0};
    tbl[2] = '{OP_CHECK,  32'h0BADF00D, 1'b0, 2 + H, 32'h0,         1'b0, 0, 1, 0};
    tbl[3] = '{5'b11111,  32'h11111111, 1'b0, 1,     32'hFFFF_FFFF, 1'b1, 0, 0, 0};
    tbl[4] = '{OP_INSERT, 32'h12345678, 1'b0, 2,     32'h0,         1'b0, 1, 0, 0};
    tbl[5] = '{5'b00000,  32'h22222222, 1'b0, 1,     32'hFFFF_FFFF, 1'b1, 0, 0, 0};
    tbl[6] = '{OP_RESET,  32'h33333333, 1'b0, 1 + C, 32'h0,         1'b0, 0, 0, C};
    tbl[7] = '{OP_CHECK,  32'h44444444, 1'b1, 2 + H, 32'h1,         1'b0, 0, 1, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_state", all_outs(), RESET_OUTS);
    rst = 1'b0;

    // Vector table
    mc = 16'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), custom_ready, 1'b1);
      custom_en = 1'b1; custom_op_ex = tbl[i].op; custom_in_RS1 = tbl[i].d;
      bloom_match = ~tbl[i].mval;
      @(negedge clk);
      custom_en = 1'b0;
      k = 1; ni = 0; nc = 0; nr = 0;
      while (!custom_valid && k < 64) begin
        ni += int'(bloom_insert); nc += int'(bloom_check); nr += int'(bloom_reset);
        bloom_match = (k == 1 + H) ? tbl[i].mval : ~tbl[i].mval;
        @(negedge clk);
        k++;
      end
      if (tbl[i].op == OP_INSERT) mc = mc + 16'd1;
      if (tbl[i].op == OP_RESET)  mc = 16'h0;
      chk($sformatf("v%0d_latency", i), k, tbl[i].lat);
      chk($sformatf("v%0d_resp", i), {custom_err, custom_result}, {tbl[i].err, tbl[i].res});
      chk($sformatf("v%0d_strobes", i), {ni[7:0], nc[7:0], nr[7:0]},
          {tbl[i].n_ins[7:0], tbl[i].n_chk[7:0], tbl[i].n_rst[7:0]});
      chk($sformatf("v%0d_count_data", i), {insert_count, bloom_data}, {mc, tbl[i].d});
    end
    bloom_match = 1'b0;

    // Clear sweep with ignored requests, starting from a nonzero count
    @(negedge clk);
    do_op(OP_INSERT, 32'h5A5A5A5A, lat);
    @(negedge clk);
    chk("pre_sweep_count", insert_count, 16'd1);
    custom_en = 1'b1; custom_op_ex = OP_RESET;
    @(negedge clk);
    for (int j = 1; j <= C; j++) begin
      chk($sformatf("sweep_%0d", j), {custom_valid, bloom_reset, bloom_insert, bloom_clr_addr, insert_count},
          {1'b0, 1'b1, 1'b0, AW'(j - 1), 16'h0});
      custom_en = 1'($urandom_range(0, 1)); custom_op_ex = OP_INSERT;
      @(negedge clk);
    end
    custom_en = 1'b0;
    chk("sweep_done", {custom_valid, custom_result, bloom_reset, bloom_clr_addr, insert_count},
        {1'b1, 32'h0, 1'b0, 4'h0, 16'h0});
    @(negedge clk);
    chk("sweep_idle", {custom_ready, custom_valid, bloom_insert}, 3'b100);

    // Abort a sweep at address 5 with rst
    @(negedge clk);
    custom_en = 1'b1; custom_op_ex = OP_RESET;
    @(negedge clk);
    custom_en = 1'b0;
    k = 0;
    while (bloom_clr_addr != 4'd5 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach_addr5", {bloom_reset, bloom_clr_addr}, {1'b1, 4'd5});
    #1 rst = 1'b1;
    #1 chk("abort_reset_outs", all_outs(), RESET_OUTS);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 25; j++) begin
      seen |= custom_valid | bloom_reset;
      @(negedge clk);
    end
    chk("abort_no_valid", seen, 1'b0);
    chk("abort_ready", custom_ready, 1'b1);

    // Saturation of insert_count, back-to-back inserts
    dut.insert_count_q = 16'hFFFE;
    for (int j = 0; j < 3; j++) begin
      do_op(OP_INSERT, 32'(j), lat);
      chk($sformatf("sat_%0d", j), {lat[7:0], insert_count}, {8'd2, 16'hFFFF});
      @(negedge clk);
    end

    // Randomized phase against the transaction model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_kind = 0; m_a = -100; m_end = -100; m_rs = '0; m_data = '0; m_cnt = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic e_ready, e_valid, e_ins, e_chk, e_rst, e_err, en;
      logic [AW-1:0] e_addr;
      logic [31:0] e_res, d;
      logic [4:0] op;
      int r, kind;

      if (m_kind == 1 && cyc == m_a + 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_kind == 3 && cyc == m_a + 1) m_cnt = 16'h0;
      if (m_kind != 0 && cyc == m_a + 1) m_data = m_rs;
      e_ready = (m_kind == 0) || (cyc > m_end);
      e_valid = (m_kind != 0) && (cyc == m_end);
      e_ins   = (m_kind == 1) && (cyc == m_a + 1);
      e_chk   = (m_kind == 2) && (cyc == m_a + 1);
      e_rst   = (m_kind == 3) && (cyc >= m_a + 1) && (cyc <= m_a + int'(C));
      e_addr  = e_rst ? AW'(cyc - m_a - 1) : '0;
      chk("rand_cycle",
          {custom_ready, custom_valid, bloom_insert, bloom_check, bloom_reset, bloom_clr_addr, insert_count, bloom_data},
          {e_ready, e_valid, e_ins, e_chk, e_rst, e_addr, m_cnt, m_data});
      if (e_valid) begin
        e_err = (m_kind == 4);
        e_res = (m_kind == 2) ? {31'b0, mh[m_a + 1 + int'(H)]} : (m_kind == 4) ? 32'hFFFF_FFFF : 32'h0;
        chk("rand_resp", {custom_err, custom_result}, {e_err, e_res});
      end

      bloom_match = 1'($urandom_range(0, 1));
      mh[cyc] = bloom_match;
      en = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      if (r < 4)      begin op = OP_INSERT; kind = 1; end
      else if (r < 8) begin op = OP_CHECK;  kind = 2; end
      else if (r < 9) begin op = OP_RESET;  kind = 3; end
      else begin
        kind = 4;
        op = 5'($urandom_range(0, 31));
        while (op == OP_INSERT || op == OP_CHECK || op == OP_RESET) op = 5'($urandom_range(0, 31));
      end
      d = $urandom;
      custom_en = en; custom_op_ex = op; custom_in_RS1 = d;
      if (en && e_ready) begin
        m_kind = kind; m_a = cyc; m_rs = d;
        case (kind)
          1: m_end = cyc + 2;
          2: m_end = cyc + 2 + int'(H);
          3: m_end = cyc + 1 + int'(C);
          default: m_end = cyc + 1;
        endcase
      end
      @(negedge clk);
    end
    custom_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
